vec_writeback: RTL and testbench

- Downstream of the vector ALU. Captures one 1024-bit ALU result of 16 lanes x 64 bits.
- Writes it into the vector register file, which has a 512-bit write port.
- Either split mode (two beats, two destination registers) or pack mode (one beat: each lane truncated to 32 bits, sticky overflow flag).
- Valid/ready on both sides. A single-entry holding buffer decouples the ALU from register-file stalls.

---
 rtl/vec_pkg.sv | 19 +
 rtl/vec_lane_pack.sv | 27 ++
 rtl/vec_writeback.sv | 153 +++++++++++++++
 tb/tb_vec_writeback.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared constants and types for the vector writeback stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vec_pkg;

  localparam int LANES  = 16;
  localparam int IN_W   = 32;
  localparam int ADDR_W = 5;
  localparam int REG_W  = LANES * IN_W;  // register file write port width
  localparam int RES_W  = 2 * REG_W;     // full ALU result width

  // Writeback sequencer states. BEAT0 writes dest_lo, BEAT1 writes dest_hi.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } wb_state_t;

endpackage

// File: rtl/vec_lane_pack.sv
// Narrows each 2*IN_W result lane to its low IN_W bits and flags lost upper bits.
// Latency: combinational.
// Backpressure: none (pure function of res_data).
//
// Ports:
//   res_data  - LANES lanes of 2*IN_W bits, lane i at [2*IN_W*i +: 2*IN_W]
//   pack_data - LANES lanes of IN_W bits, lane i at [IN_W*i +: IN_W]
//   pack_ovf  - 1 when any lane has a nonzero upper half
module vec_lane_pack #(
  parameter int LANES = vec_pkg::LANES,
  parameter int IN_W  = vec_pkg::IN_W
) (
  input  logic [2*LANES*IN_W-1:0] res_data,
  output logic [LANES*IN_W-1:0]   pack_data,
  output logic                    pack_ovf
);

  always_comb begin
    pack_data = '0;
    pack_ovf  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      pack_data[IN_W*i +: IN_W] = res_data[2*IN_W*i +: IN_W];
      pack_ovf = pack_ovf | (|res_data[2*IN_W*i + IN_W +: IN_W]);
    end
  end

endmodule

// File: rtl/vec_writeback.sv
// Writes one vector ALU result into the register file as two 512-bit beats (split) or one truncated beat (pack).
// Latency: write request visible the cycle after accept; done pulses the cycle after the last beat is taken.
// Backpressure: wr_ready low holds the current beat; res_ready only rises when the buffer frees this cycle.
//
// Ports:
//   clk, rst_n                        - clock, async active-low reset
//   res_valid/res_ready, res_data     - ALU result handshake and payload
//   res_pack, dest_lo, dest_hi        - mode select and destination registers
//   wr_en/wr_ready, wr_addr, wr_data  - register file write handshake
//   ovf, ovf_clr                      - sticky pack overflow flag and its clear
//   done                              - pulse after the final beat of a result is accepted
module vec_writeback #(
  parameter int LANES  = vec_pkg::LANES,
  parameter int IN_W   = vec_pkg::IN_W,
  parameter int ADDR_W = vec_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [2*LANES*IN_W-1:0] res_data,
  input  logic                    res_pack,
  input  logic [ADDR_W-1:0]       dest_lo,
  input  logic [ADDR_W-1:0]       dest_hi,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [LANES*IN_W-1:0]   wr_data,
  output logic                    ovf,
  input  logic                    ovf_clr,
  output logic                    done
);
  import vec_pkg::*;

  localparam int REG_W = LANES * IN_W;
  localparam int RES_W = 2 * REG_W;

  wb_state_t state_q, state_d;

  // Holding buffer: beat 0 is loaded straight into the output registers at
  // accept, so only the second beat and its address need to be kept here.
  logic [REG_W-1:0]  buf_hi_data;
  logic [ADDR_W-1:0] buf_hi_addr;
  logic              buf_pack;

  logic [REG_W-1:0]  pack_data;
  logic              pack_ovf;

  logic              last_beat;
  logic              last_done;
  logic              accept;
  logic              advance_hi;

  vec_lane_pack #(
    .LANES (LANES),
    .IN_W  (IN_W)
  ) u_lane_pack (
    .res_data  (res_data),
    .pack_data (pack_data),
    .pack_ovf  (pack_ovf)
  );

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_beat  = 1'b0;
    last_done  = 1'b0;
    res_ready  = 1'b0;
    accept     = 1'b0;
    advance_hi = 1'b0;

    // A pack result finishes in BEAT0; a split result finishes in BEAT1.
    last_beat = (state_q == BEAT1) || ((state_q == BEAT0) && buf_pack);
    last_done = last_beat && wr_ready;
    // Accepting while the last beat drains gives back-to-back results with no
    // bubble; res_valid is deliberately kept out of this term.
    res_ready = (state_q == IDLE) || last_done;
    accept    = res_valid && res_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = BEAT0;
      end
      BEAT0: begin
        if (wr_ready) begin
          if (!buf_pack) begin
            state_d    = BEAT1;
            advance_hi = 1'b1;
          end else begin
            state_d = accept ? BEAT0 : IDLE;
          end
        end
      end
      BEAT1: begin
        if (wr_ready) state_d = accept ? BEAT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Datapath: output registers only change on accept or on the BEAT0->BEAT1
  // step, so address and data are stable for as long as wr_ready is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr     <= '0;
      wr_data     <= '0;
      buf_hi_data <= '0;
      buf_hi_addr <= '0;
      buf_pack    <= 1'b0;
    end else if (accept) begin
      wr_addr     <= dest_lo;
      wr_data     <= res_pack ? pack_data : res_data[REG_W-1:0];
      buf_hi_data <= res_data[RES_W-1:REG_W];
      buf_hi_addr <= dest_hi;
      buf_pack    <= res_pack;
    end else if (advance_hi) begin
      wr_addr <= buf_hi_addr;
      wr_data <= buf_hi_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion pulse and sticky overflow (set beats clear in the same cycle)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= last_done;
      if (accept && res_pack && pack_ovf) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_writeback.sv
// Directed bench for vec_writeback: split, pack, overflow, stall, back-to-back, mid-op reset.
// Latency: n/a.
// Backpressure: driven explicitly through wr_ready.
module tb_vec_writeback;
  import vec_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              res_pack;
  logic [ADDR_W-1:0] dest_lo;
  logic [ADDR_W-1:0] dest_hi;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [REG_W-1:0]  wr_data;
  logic              ovf;
  logic              ovf_clr;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [REG_W-1:0] exp_lo, exp_hi, exp_pk;

  always #5 clk = ~clk;

  vec_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_pack  (res_pack),
    .dest_lo   (dest_lo),
    .dest_hi   (dest_hi),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [REG_W-1:0] got, input logic [REG_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; leave time 1ns after the edge for checks and drives.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_pack  = 1'b0;
    dest_lo   = '0;
    dest_hi   = '0;
    wr_ready  = 1'b0;
    ovf_clr   = 1'b0;
    #12;
    chk("rst_wr_en",     wr_en,     0);
    chk("rst_wr_addr",   wr_addr,   0);
    chk("rst_wr_data",   wr_data,   0);
    chk("rst_ovf",       ovf,       0);
    chk("rst_done",      done,      0);
    rst_n = 1'b1;
    #1;
    chk("rst_res_ready", res_ready, 1);
    tick();

    // ---- Split, wr_ready=1: lane i = 2^32 + i --------------------------------
    for (int i = 0; i < 16; i++) res_data[64*i +: 64] = 64'h1_0000_0000 + 64'(i);
    for (int i = 0; i < 8; i++)  exp_lo[64*i +: 64] = 64'h1_0000_0000 + 64'(i);
    for (int i = 8; i < 16; i++) exp_hi[64*(i-8) +: 64] = 64'h1_0000_0000 + 64'(i);
    res_pack  = 1'b0;
    dest_lo   = 5'd3;
    dest_hi   = 5'd4;
    wr_ready  = 1'b1;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("split_b0_en",    wr_en,     1);
    chk("split_b0_addr",  wr_addr,   3);
    chk("split_b0_data",  wr_data,   exp_lo);
    chk("split_b0_rdy",   res_ready, 0);
    tick();
    chk("split_b1_en",    wr_en,     1);
    chk("split_b1_addr",  wr_addr,   4);
    chk("split_b1_data",  wr_data,   exp_hi);
    chk("split_b1_done",  done,      0);
    chk("split_b1_rdy",   res_ready, 1);
    tick();
    chk("split_idle_en",  wr_en,     0);
    chk("split_done",     done,      1);
    chk("split_ovf",      ovf,       0);
    tick();
    chk("split_done_1cy", done,      0);

    // ---- Pack, lane i = 3*i ------------------------------------------------
    for (int i = 0; i < 16; i++) res_data[64*i +: 64] = 64'(3 * i);
    for (int i = 0; i < 16; i++) exp_pk[32*i +: 32] = 32'(3 * i);
    res_pack  = 1'b1;
    dest_lo   = 5'd7;
    dest_hi   = 5'd9;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("pack_en",        wr_en,     1);
    chk("pack_addr",      wr_addr,   7);
    chk("pack_data",      wr_data,   exp_pk);
    chk("pack_rdy",       res_ready, 1);
    tick();
    chk("pack_idle_en",   wr_en,     0);
    chk("pack_done",      done,      1);
    chk("pack_ovf0",      ovf,       0);

    // ---- Pack with overflow in lane 5 --------------------------------------
    res_data[64*5 +: 64] = 64'h2_0000_0007;
    exp_pk[32*5 +: 32]   = 32'd7;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("povf_data",      wr_data,   exp_pk);
    chk("povf_ovf",       ovf,       1);
    tick();
    tick();
    chk("povf_sticky",    ovf,       1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("povf_clr",       ovf,       0);

    // ---- Split with wr_ready low for 4 cycles in BEAT0 ---------------------
    for (int i = 0; i < 16; i++) res_data[64*i +: 64] = {32'hA5A5_0000 + 32'(i), 32'h0F0F_0000 + 32'(i)};
    for (int i = 0; i < 8; i++)  exp_lo[64*i +: 64] = {32'hA5A5_0000 + 32'(i), 32'h0F0F_0000 + 32'(i)};
    for (int i = 8; i < 16; i++) exp_hi[64*(i-8) +: 64] = {32'hA5A5_0000 + 32'(i), 32'h0F0F_0000 + 32'(i)};
    res_pack  = 1'b0;
    dest_lo   = 5'd10;
    dest_hi   = 5'd11;
    wr_ready  = 1'b0;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("stall_en",     wr_en,     1);
      chk("stall_addr",   wr_addr,   10);
      chk("stall_data",   wr_data,   exp_lo);
      chk("stall_rdy",    res_ready, 0);
      tick();
    end
    wr_ready = 1'b1;
    chk("stall_rel_addr", wr_addr,   10);
    tick();
    chk("stall_b1_addr",  wr_addr,   11);
    chk("stall_b1_data",  wr_data,   exp_hi);
    tick();
    chk("stall_done",     done,      1);
    chk("stall_ovf",      ovf,       0);

    // ---- Back-to-back: pack A then split B ---------------------------------
    for (int i = 0; i < 16; i++) res_data[64*i +: 64] = 64'(i + 100);
    for (int i = 0; i < 16; i++) exp_pk[32*i +: 32] = 32'(i + 100);
    res_pack  = 1'b1;
    dest_lo   = 5'd1;
    dest_hi   = 5'd31;
    res_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) res_data[64*i +: 64] = 64'hCAFE_0000_0000_0000 | 64'(i);
    for (int i = 0; i < 8; i++)  exp_lo[64*i +: 64] = 64'hCAFE_0000_0000_0000 | 64'(i);
    for (int i = 8; i < 16; i++) exp_hi[64*(i-8) +: 64] = 64'hCAFE_0000_0000_0000 | 64'(i);
    res_pack = 1'b0;
    dest_lo  = 5'd2;
    dest_hi  = 5'd3;
    #1;
    chk("b2b_a_addr",     wr_addr,   1);
    chk("b2b_a_data",     wr_data,   exp_pk);
    chk("b2b_a_rdy",      res_ready, 1);
    tick();
    res_valid = 1'b0;
    chk("b2b_b0_en",      wr_en,     1);
    chk("b2b_b0_addr",    wr_addr,   2);
    chk("b2b_b0_data",    wr_data,   exp_lo);
    chk("b2b_a_done",     done,      1);
    tick();
    chk("b2b_b1_en",      wr_en,     1);
    chk("b2b_b1_addr",    wr_addr,   3);
    chk("b2b_b1_data",    wr_data,   exp_hi);
    chk("b2b_b1_done",    done,      0);
    tick();
    chk("b2b_idle_en",    wr_en,     0);
    chk("b2b_b_done",     done,      1);
    chk("b2b_ovf",        ovf,       0);

    // ---- ovf_clr and overflowing pack accept in the same cycle -------------
    for (int i = 0; i < 16; i++) res_data[64*i +: 64] = 64'(i);
    res_data[64*15 +: 64] = 64'h8000_0000_0000_0001;
    res_pack  = 1'b1;
    dest_lo   = 5'd20;
    ovf_clr   = 1'b1;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    ovf_clr   = 1'b0;
    chk("setclr_ovf",     ovf,       1);
    tick();
    chk("setclr_done",    done,      1);

    // ---- Reset asserted during BEAT1 ---------------------------------------
    for (int i = 0; i < 16; i++) res_data[64*i +: 64] = 64'h1234_5678_9ABC_DEF0 ^ 64'(i);
    res_pack  = 1'b0;
    dest_lo   = 5'd5;
    dest_hi   = 5'd6;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    tick();
    chk("mrst_b1_en",     wr_en,     1);
    chk("mrst_b1_addr",   wr_addr,   6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_en_async",  wr_en,     0);
    chk("mrst_ovf_async", ovf,       0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mrst_post_en",   wr_en,     0);
      chk("mrst_post_done", done,      0);
      chk("mrst_post_rdy",  res_ready, 1);
      chk("mrst_post_ovf",  ovf,       0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
